// File: rtl/mdc_reconfig_sequencer_pkg.sv
// Shared definitions for the MDC reconfiguration sequencer: ID width, kernel IDs
// and the one-hot FSM state encoding.
package mdc_reconfig_sequencer_pkg;

    localparam int CFG_ID_WIDTH = 8;

    localparam int ID_MACNET   = 1;
    localparam int ID_MULNET   = 2;
    localparam int ID_MMUL_PAR = 3;

    typedef enum logic [3:0] {
        ST_RUN    = 4'b0001,
        ST_DRAIN  = 4'b0010,
        ST_SWITCH = 4'b0100,
        ST_SETTLE = 4'b1000
    } state_e;

endpackage

// File: rtl/mdc_reconfig_sequencer.sv
// Stalls the input stream, waits for the datapath to drain, then swaps the
// configurator kernel ID and holds a settle window before reopening the stream.
module mdc_reconfig_sequencer
    import mdc_reconfig_sequencer_pkg::*;
#(
    parameter int ID_WIDTH      = CFG_ID_WIDTH,
    parameter int N_KERNELS     = ID_MMUL_PAR,
    parameter int RESET_ID      = ID_MACNET,
    parameter int DRAIN_CYCLES  = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                req_valid_i,
    input  logic [ID_WIDTH-1:0] req_id_i,
    output logic                req_ready_o,
    output logic [ID_WIDTH-1:0] cfg_id_o,
    output logic                cfg_done_o,
    output logic                cfg_err_o,
    output logic                busy_o,
    input  logic                src_valid_i,
    output logic                src_ready_o,
    output logic                dp_valid_o,
    input  logic                dp_ready_i,
    input  logic                dp_idle_i
);

    localparam int IW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;
    localparam int SW = (SETTLE_CYCLES > 0) ? (($clog2(SETTLE_CYCLES + 1) > 1) ? $clog2(SETTLE_CYCLES + 1) : 1) : 1;
    localparam logic [IW-1:0] IDLE_LAST   = IW'(DRAIN_CYCLES - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    localparam logic [ID_WIDTH-1:0] ID_RST = ID_WIDTH'(RESET_ID);
    localparam logic [ID_WIDTH-1:0] ID_MAX = ID_WIDTH'(N_KERNELS);

    state_e              state, state_n;
    logic [ID_WIDTH-1:0] pending_id, pending_id_n, cfg_id_n;
    logic [IW-1:0]       idle_cnt, idle_cnt_n;
    logic [SW-1:0]       settle_cnt, settle_cnt_n;
    logic                done_n, err_n, id_ok;

    assign id_ok       = (req_id_i != '0) && (req_id_i <= ID_MAX);
    assign req_ready_o = (state == ST_RUN);
    assign busy_o      = (state != ST_RUN);
    // A beat handshaken in the accept cycle still completes; gating bites next cycle.
    assign src_ready_o = dp_ready_i & (state == ST_RUN);
    assign dp_valid_o  = src_valid_i & (state == ST_RUN);

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_RUN;
            cfg_id_o   <= ID_RST;
            pending_id <= ID_RST;
            idle_cnt   <= '0;
            settle_cnt <= '0;
            cfg_done_o <= 1'b0;
            cfg_err_o  <= 1'b0;
        end else begin
            state      <= state_n;
            cfg_id_o   <= cfg_id_n;
            pending_id <= pending_id_n;
            idle_cnt   <= idle_cnt_n;
            settle_cnt <= settle_cnt_n;
            cfg_done_o <= done_n;
            cfg_err_o  <= err_n;
        end
    end

    always_comb begin
        state_n      = state;
        cfg_id_n     = cfg_id_o;
        pending_id_n = pending_id;
        idle_cnt_n   = idle_cnt;
        settle_cnt_n = settle_cnt;
        done_n       = 1'b0;
        err_n        = 1'b0;
        case (state)
            ST_RUN: begin
                if (req_valid_i) begin
                    if (!id_ok) begin
                        err_n = 1'b1;
                    end else if (req_id_i == cfg_id_o) begin
                        done_n = 1'b1;
                    end else begin
                        pending_id_n = req_id_i;
                        idle_cnt_n   = '0;
                        state_n      = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // Any busy cycle restarts the run of consecutive idle cycles.
                if (!dp_idle_i) begin
                    idle_cnt_n = '0;
                end else if (idle_cnt == IDLE_LAST) begin
                    idle_cnt_n = '0;
                    state_n    = ST_SWITCH;
                end else begin
                    idle_cnt_n = idle_cnt + 1'b1;
                end
            end
            ST_SWITCH: begin
                cfg_id_n     = pending_id;
                settle_cnt_n = '0;
                if (SETTLE_CYCLES == 0) begin
                    state_n = ST_RUN;
                    done_n  = 1'b1;
                end else begin
                    state_n = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_cnt == SETTLE_LAST) begin
                    settle_cnt_n = '0;
                    state_n      = ST_RUN;
                    done_n       = 1'b1;
                end else begin
                    settle_cnt_n = settle_cnt + 1'b1;
                end
            end
            default: state_n = ST_RUN;
        endcase
    end

endmodule
